// File: rtl/alu_noc_pkg.sv
// Shared types and helpers for the ALU NoC tile host-side logic.
package alu_noc_pkg;

   localparam int ALU_DATA_W = 64;
   localparam int ALU_CTRL_W = 16;
   localparam int STAT_W     = 16;

   // One operation as offered to the tile host port.
   typedef struct packed {
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
      logic [ALU_CTRL_W-1:0] ctrl;
   } alu_req_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } inj_state_t;

   // Status counters stick at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO: power-of-two depth, wrapping pointers plus a
// separate occupancy counter so full and empty are unambiguous.
module alu_req_fifo
   import alu_noc_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  alu_req_t         push_data,
   input  logic             pop,
   output alu_req_t         pop_data,
   output logic             full,
   output logic             empty,
   output logic [OCC_W-1:0] occupancy
);

   alu_req_t         mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (occupancy == OCC_W'(FIFO_DEPTH));
   assign empty    = (occupancy == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop cancel out.
   always_ff @(posedge clk) begin
      // NOTE: state registers use <= so every flop samples pre-edge values;
      // blocking = here would make results depend on statement order.
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; occupancy gates every read,
      // so stale contents are never observed and the RAM stays reset-free.
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/alu_tile_host_injector.sv
// Host-port injector for one ALU tile: buffers requests, injects one at a
// time, waits for the tile result or a timeout, and returns a response.
module alu_tile_host_injector
   import alu_noc_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ALU_DATA_W-1:0] req_a,
   input  logic [ALU_DATA_W-1:0] req_b,
   input  logic [ALU_CTRL_W-1:0] req_ctrl,
   output logic [ALU_DATA_W-1:0] host_in_a,
   output logic [ALU_DATA_W-1:0] host_in_b,
   output logic [ALU_CTRL_W-1:0] host_in_ctrl,
   output logic                  host_in_valid,
   input  logic [ALU_DATA_W-1:0] host_out_a,
   input  logic                  host_out_valid,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ALU_DATA_W-1:0] rsp_data,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [STAT_W-1:0]     stray_count,
   output logic [STAT_W-1:0]     timeout_count
);

   localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
   localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

   inj_state_t        state;
   inj_state_t        state_next;
   alu_req_t          req_in;
   alu_req_t          fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [OCC_W-1:0]  fifo_occ;
   logic [WCNT_W-1:0] wait_cnt;
   logic              inject;
   logic              result_hit;
   logic              timeout_hit;
   logic              rsp_fire;

   assign req_in = '{a: req_a, b: req_b, ctrl: req_ctrl};

   alu_req_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid && req_ready),
      .push_data (req_in),
      .pop       (inject),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .occupancy (fifo_occ)
   );

   assign req_ready = !fifo_full;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE) || (fifo_occ != '0);
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign inject    = (state == IDLE) && !fifo_empty;

   // The injection cycle itself is not counted toward the timeout: the tile
   // only sees the operation during that cycle. A result in the last counted
   // cycle beats the timeout.
   assign result_hit  = (state == WAIT) && host_out_valid;
   assign timeout_hit = (state == WAIT) && !host_out_valid && !host_in_valid
                        && (wait_cnt == WCNT_LAST);

   // Next-state logic.
   always_comb begin
      // NOTE: defaulting state_next before the case keeps every path assigned,
      // so no latch is inferred for unlisted states or conditions.
      state_next = state;
      case (state)
         IDLE:    if (inject) state_next = WAIT;
         WAIT:    if (result_hit || timeout_hit) state_next = RESP;
         RESP:    if (rsp_fire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Injection registers: operands hold their last value between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         host_in_a     <= '0;
         host_in_b     <= '0;
         host_in_ctrl  <= '0;
         host_in_valid <= 1'b0;
      end else begin
         host_in_valid <= inject;
         if (inject) begin
            host_in_a    <= fifo_head.a;
            host_in_b    <= fifo_head.b;
            host_in_ctrl <= fifo_head.ctrl;
         end
      end
   end

   // Wait counter: cleared on injection, advances each counted WAIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (inject) begin
         wait_cnt <= '0;
      end else if ((state == WAIT) && !host_in_valid && (wait_cnt != WCNT_LAST)) begin
         wait_cnt <= wait_cnt + WCNT_W'(1);
      end
   end

   // Response register: written only on leaving WAIT, so strays cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
      end else if (result_hit) begin
         rsp_data    <= host_out_a;
         rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
         rsp_data    <= '0;
         rsp_timeout <= 1'b1;
      end
   end

   // Saturating status counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stray_count   <= '0;
         timeout_count <= '0;
      end else begin
         if (host_out_valid && (state != WAIT)) stray_count <= sat_inc(stray_count);
         if (timeout_hit) timeout_count <= sat_inc(timeout_count);
      end
   end

endmodule

// File: tb/tb_alu_tile_host_injector.sv
// Scenario bench for alu_tile_host_injector with a response scoreboard.
module tb_alu_tile_host_injector;
   import alu_noc_pkg::*;

   localparam int DEPTH = 4;
   localparam int TC    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [63:0] req_a, req_b;
   logic [15:0] req_ctrl;
   logic [63:0] host_in_a, host_in_b;
   logic [15:0] host_in_ctrl;
   logic        host_in_valid;
   logic [63:0] host_out_a;
   logic        host_out_valid;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_timeout;
   logic        busy;
   logic [15:0] stray_count, timeout_count;

   alu_tile_host_injector #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_ctrl       (req_ctrl),
      .host_in_a      (host_in_a),
      .host_in_b      (host_in_b),
      .host_in_ctrl   (host_in_ctrl),
      .host_in_valid  (host_in_valid),
      .host_out_a     (host_out_a),
      .host_out_valid (host_out_valid),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_timeout    (rsp_timeout),
      .busy           (busy),
      .stray_count    (stray_count),
      .timeout_count  (timeout_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        timeout;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [15:0] exp_stray = '0;
   logic [15:0] exp_tmo   = '0;

   // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_pulse(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (host_in_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic offer(input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_ctrl  = c;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_ctrl = '0;
      host_out_a = '0; host_out_valid = 1'b0; rsp_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      checks++; if (host_in_valid !== 1'b0) begin errors++; $display("FAIL reset_host_in_valid got %b want 0", host_in_valid); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (rsp_data !== 64'd0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_data, rsp_timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (stray_count !== 16'd0 || timeout_count !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", stray_count, timeout_count); end
      checks++; if (host_in_a !== 64'd0 || host_in_b !== 64'd0 || host_in_ctrl !== 16'd0) begin errors++; $display("FAIL reset_host_in got %h/%h/%h want 0", host_in_a, host_in_b, host_in_ctrl); end
   endtask

   task automatic test_single_op();
      exp_t e;
      offer(64'd5, 64'd7, 16'h0001);
      sb.push_back('{data: 64'd12, timeout: 1'b0});
      tick();                                                // t+1
      req_valid = 1'b0;
      checks++; if (host_in_valid !== 1'b0) begin errors++; $display("FAIL single_early_pulse got %b want 0", host_in_valid); end
      tick();                                                // t+2
      checks++; if (host_in_valid !== 1'b1) begin errors++; $display("FAIL single_pulse got %b want 1", host_in_valid); end
      checks++; if (host_in_a !== 64'd5 || host_in_b !== 64'd7 || host_in_ctrl !== 16'h0001) begin errors++; $display("FAIL single_operands got %0d/%0d/%h want 5/7/0001", host_in_a, host_in_b, host_in_ctrl); end
      tick();                                                // t+3
      checks++; if (host_in_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", host_in_valid); end
      checks++; if (host_in_a !== 64'd5) begin errors++; $display("FAIL single_hold got %0d want 5", host_in_a); end
      tick();                                                // t+4
      tick();                                                // t+5
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early got %b want 0", rsp_valid); end
      host_out_valid = 1'b1; host_out_a = 64'd12;
      tick();                                                // t+6
      host_out_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
      if (sb.size() == 0) begin
         checks++; errors++; $display("FAIL single_sb_empty got 0 entries want 1");
      end else begin
         e = sb.pop_front();
         checks++; if (rsp_data !== e.data || rsp_timeout !== e.timeout) begin errors++; $display("FAIL single_rsp got %0d/%b want %0d/%b", rsp_data, rsp_timeout, e.data, e.timeout); end
      end
      rsp_ready = 1'b1;
      tick();                                                // t+7
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
   endtask

   task automatic test_timeout();
      exp_t e;
      bit   seen;
      int   n;
      offer(64'd100, 64'd1, 16'h0002);
      sb.push_back('{data: 64'd0, timeout: 1'b1});
      tick();
      req_valid = 1'b0;
      wait_pulse(10, seen);
      checks++; if (!seen) begin errors++; $display("FAIL timeout_pulse got none want pulse"); end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++; if (n != TC + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", n, TC + 1); end
      e = sb.pop_front();
      checks++; if (rsp_data !== e.data || rsp_timeout !== e.timeout) begin errors++; $display("FAIL timeout_rsp got %h/%b want %h/%b", rsp_data, rsp_timeout, e.data, e.timeout); end
      exp_tmo = exp_tmo + 16'd1;
      checks++; if (timeout_count !== exp_tmo) begin errors++; $display("FAIL timeout_count got %0d want %0d", timeout_count, exp_tmo); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_tie();
      exp_t e;
      bit   seen;
      offer(64'd3, 64'd4, 16'h0003);
      tick();
      req_valid = 1'b0;
      wait_pulse(10, seen);
      checks++; if (!seen) begin errors++; $display("FAIL tie_pulse got none want pulse"); end
      for (int i = 0; i < TC; i++) tick();                   // last counted WAIT cycle
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tie_early got %b want 0", rsp_valid); end
      host_out_valid = 1'b1; host_out_a = 64'hDEAD_BEEF;
      sb.push_back('{data: 64'hDEAD_BEEF, timeout: 1'b0});
      tick();
      host_out_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL tie_rsp_valid got %b want 1", rsp_valid); end
      e = sb.pop_front();
      checks++; if (rsp_data !== e.data || rsp_timeout !== e.timeout) begin errors++; $display("FAIL tie_rsp got %h/%b want %h/%b", rsp_data, rsp_timeout, e.data, e.timeout); end
      checks++; if (timeout_count !== exp_tmo) begin errors++; $display("FAIL tie_timeout_count got %0d want %0d", timeout_count, exp_tmo); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_stray_backpressure();
      exp_t e;
      bit   seen;
      host_out_valid = 1'b1; host_out_a = 64'hBAD;           // stray while IDLE
      exp_stray = exp_stray + 16'd1;
      tick();
      host_out_valid = 1'b0;
      offer(64'h1000, 64'h0234, 16'h0004);
      sb.push_back('{data: 64'h1234, timeout: 1'b0});
      tick();
      req_valid = 1'b0;
      wait_pulse(10, seen);
      checks++; if (!seen) begin errors++; $display("FAIL stray_pulse got none want pulse"); end
      tick();
      host_out_valid = 1'b1; host_out_a = 64'h1234;
      tick();
      host_out_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h1234 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL stray_hold_%0d got %b/%h/%b want 1/1234/0", i, rsp_valid, rsp_data, rsp_timeout);
         end
         if (i == 2 || i == 5) begin
            host_out_valid = 1'b1; host_out_a = '1;
            exp_stray = exp_stray + 16'd1;
         end else begin
            host_out_valid = 1'b0;
         end
         tick();
      end
      host_out_valid = 1'b0;
      checks++; if (stray_count !== exp_stray) begin errors++; $display("FAIL stray_count got %0d want %0d", stray_count, exp_stray); end
      e = sb.pop_front();
      checks++; if (rsp_data !== e.data || rsp_timeout !== e.timeout) begin errors++; $display("FAIL stray_rsp got %h/%b want %h/%b", rsp_data, rsp_timeout, e.data, e.timeout); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stray_rsp_drop got %b want 0", rsp_valid); end
   endtask

   task automatic test_fill_back_to_back();
      exp_t        e;
      bit          seen;
      bit          pend;
      int          dly;
      int          got;
      int          last_pulse;
      logic [63:0] pend_data;
      // First op parks in RESP so the following pushes accumulate.
      offer(64'd10, 64'd1, 16'h0010);
      sb.push_back('{data: 64'd11, timeout: 1'b0});
      tick();
      req_valid = 1'b0;
      wait_pulse(10, seen);
      tick(); tick();
      host_out_valid = 1'b1; host_out_a = 64'd11;
      tick();
      host_out_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", k, req_ready); end
         offer(64'(20 + k), 64'(k), 16'(k));
         sb.push_back('{data: 64'(20 + 2 * k), timeout: 1'b0});
         tick();
      end
      offer(64'd99, 64'd99, 16'h0099);                       // must be refused
      checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fill_full got ready %b busy %b want 0/1", req_ready, busy); end
      tick();
      req_valid = 1'b0;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_still_full got %b want 0", req_ready); end
      e = sb.pop_front();
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== e.data) begin errors++; $display("FAIL fill_first_rsp got %b/%0d want 1/%0d", rsp_valid, rsp_data, e.data); end
      rsp_ready = 1'b1;
      tick();                                                // d+1
      rsp_ready = 1'b0;
      checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL fill_d1 got ready %b rsp %b want 0/0", req_ready, rsp_valid); end
      tick();                                                // d+2
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got %b want 1", req_ready); end
      checks++; if (host_in_valid !== 1'b1 || host_in_a !== 64'd20) begin errors++; $display("FAIL fill_next_pulse got %b/%0d want 1/20", host_in_valid, host_in_a); end
      offer(64'd40, 64'd2, 16'h0040);
      sb.push_back('{data: 64'd42, timeout: 1'b0});
      rsp_ready  = 1'b1;
      pend       = 1'b0;
      dly        = 0;
      got        = 0;
      last_pulse = -1;
      pend_data  = '0;
      for (int i = 0; i < 200 && got < 5; i++) begin
         if (i == 1) req_valid = 1'b0;
         host_out_valid = 1'b0;
         if (pend) begin
            if (dly == 0) begin
               host_out_valid = 1'b1; host_out_a = pend_data; pend = 1'b0;
            end else begin
               dly--;
            end
         end
         if (host_in_valid === 1'b1) begin
            if (last_pulse >= 0) begin
               checks++; if (cyc - last_pulse < 4) begin errors++; $display("FAIL b2b_gap got %0d want >=4", cyc - last_pulse); end
            end
            last_pulse = cyc;
            pend = 1'b1; dly = 1; pend_data = host_in_a + host_in_b;
         end
         if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL drain_sb_empty got extra rsp %0d want none", rsp_data);
            end else begin
               e = sb.pop_front();
               checks++; if (rsp_data !== e.data || rsp_timeout !== e.timeout) begin errors++; $display("FAIL drain_rsp_%0d got %0d/%b want %0d/%b", got, rsp_data, rsp_timeout, e.data, e.timeout); end
            end
            got++;
         end
         tick();
      end
      rsp_ready = 1'b0; host_out_valid = 1'b0;
      checks++; if (got != 5) begin errors++; $display("FAIL drain_count got %0d want 5", got); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy got %b want 0", busy); end
   endtask

   task automatic test_reset_in_wait();
      int bad;
      for (int k = 0; k < 3; k++) begin
         offer(64'(50 + k), 64'd1, 16'h0050);
         tick();
      end
      req_valid = 1'b0;
      checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_pre got busy %b rsp %b want 1/0", busy, rsp_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_stray = '0;
      exp_tmo   = '0;
      checks++; if (host_in_valid !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rstw_outputs got inv %b rsp %b busy %b rdy %b want 0/0/0/1", host_in_valid, rsp_valid, busy, req_ready);
      end
      checks++; if (host_in_a !== 64'd0 || rsp_data !== 64'd0 || stray_count !== exp_stray || timeout_count !== exp_tmo) begin
         errors++; $display("FAIL rstw_regs got %0d/%0d/%0d/%0d want 0/0/0/0", host_in_a, rsp_data, stray_count, timeout_count);
      end
      host_out_valid = 1'b1; host_out_a = 64'd77;
      exp_stray = exp_stray + 16'd1;
      tick();
      host_out_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (rsp_valid !== 1'b0 || host_in_valid !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rstw_quiet got %0d active cycles want 0", bad); end
      checks++; if (stray_count !== exp_stray) begin errors++; $display("FAIL rstw_stray got %0d want %0d", stray_count, exp_stray); end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_timeout();
      test_tie();
      test_stray_backpressure();
      test_fill_back_to_back();
      test_reset_in_wait();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_tile_host_injector.md
# alu_tile_host_injector

Host-side endpoint for one ALU NoC tile's host port: accepts operation requests (a, b, ctrl) over a valid/ready interface, buffers them, and injects them one at a time as single-cycle `host_in_*` pulses into the tile. It then waits for the tile's `host_out_valid` result, or a timeout, and returns the result over a valid/ready response interface. The tile port has no backpressure and no tags, so exactly one operation is outstanding at a time.

## Interface
- `FIFO_DEPTH`, 4: request buffer entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before a timeout response; ≥1.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request buffer not full.
- `req_a` in 64: operand A.
- `req_b` in 64: operand B.
- `req_ctrl` in 16: tile control word.
- `host_in_a` out 64: operand A to tile.
- `host_in_b` out 64: operand B to tile.
- `host_in_ctrl` out 16: control word to tile.
- `host_in_valid` out 1: one-cycle injection pulse.
- `host_out_a` in 64: tile result.
- `host_out_valid` in 1: tile result valid.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out 64: result; 0 on timeout.
- `rsp_timeout` out 1: response produced by timeout.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `stray_count` out 16: saturating count of `host_out_valid` outside WAIT.
- `timeout_count` out 16: saturating count of timeouts.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE with FIFO non-empty:
  - Pop the head into the `host_in_a/b/ctrl` registers.
  - Set `host_in_valid`=1 for the next cycle only.
  - Go to WAIT and clear the wait counter.
- WAIT:
  - If `host_out_valid`: capture `host_out_a` into `rsp_data`, set `rsp_timeout`=0, go to RESP.
  - Else, if the wait counter == `TIMEOUT_CYCLES`-1: set `rsp_data`=0, set `rsp_timeout`=1, increment `timeout_count`, go to RESP.
  - Else: increment the wait counter.
  - If `host_out_valid` arrives in the same cycle the timeout would fire, the result wins and no timeout is counted.
- RESP:
  - `rsp_valid`=1.
  - `rsp_data` and `rsp_timeout` are held stable until `rsp_valid && rsp_ready`; then go to IDLE.
- `host_out_valid` in IDLE or RESP increments `stray_count` and is otherwise ignored; `rsp_data` is not disturbed.
- `host_in_a/b/ctrl` hold the last injected values between pulses.
- FIFO:
  - Push on `req_valid && req_ready`.
  - Simultaneous push and pop leaves the occupancy unchanged.
  - Wrap-around uses a log2(`FIFO_DEPTH`) pointer plus a separate occupancy counter.
- The wait counter is $clog2(`TIMEOUT_CYCLES`+1) bits wide. Status counters stop at 16'hFFFF.

## Timing
- Reset values: all outputs 0 (`req_ready` 1 once reset is released), FIFO empty, state IDLE, counters 0.
- `req_ready` is combinational from occupancy (`occupancy` != `FIFO_DEPTH`). A pop at full raises `req_ready` the following cycle.
- Request accepted at cycle t into an empty FIFO in IDLE → `host_in_valid` high in cycle t+2 only.
- `host_out_valid` in WAIT cycle c → `rsp_valid` high from c+1.
- Timeout: with no result, `rsp_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after the `host_in_valid` cycle.
- Response handshake in cycle d → `rsp_valid` 0 at d+1 (IDLE). The next `host_in_valid` is no earlier than d+2.
- Back-to-back injections are therefore separated by at least 4 cycles.
- `rst` asserted in any state, sampled on a clock edge:
  - FIFO flushed, in-flight operation abandoned, outputs return to reset values next cycle.
  - A later tile result is counted as stray.

## Structure
- Shared package `alu_noc_pkg`:
  - `ALU_DATA_W`=64, `ALU_CTRL_W`=16.
  - `alu_req_t` struct {a, b, ctrl}.
  - `inj_state_t` enum {IDLE, WAIT, RESP}.
- Sub-module `alu_req_fifo`:
  - Synchronous FIFO of `alu_req_t` with push, pop, full, empty, occupancy.
  - Parameterized by `FIFO_DEPTH`.
- Top module contains the FSM, wait counter, response register, and status counters.

## Test plan
- Single op: request a=5, b=7, ctrl=16'h0001 at t. Expected: `host_in_*`=5/7/1 with valid in t+2 only. Drive `host_out_a`=12 at t+5. Expected: `rsp_valid` at t+6 with `rsp_data`=12 and `rsp_timeout`=0.
- Fill: push 4 requests with `rsp_ready`=0. Expected: `req_ready` 0 after the 4th push. First injection pops one entry. Expected: `req_ready` 1 the next cycle, and a 5th push is accepted. Then drain with `rsp_ready`=1. Expected: 5 responses in request order.
- Timeout: `TIMEOUT_CYCLES`=8, tile never responds. Expected: `rsp_valid` 9 cycles after the injection pulse, `rsp_data`=0, `rsp_timeout`=1, `timeout_count`=1.
- Tie: result arrives in the final WAIT cycle. Expected: `rsp_timeout`=0, the correct data, `timeout_count` unchanged.
- Stray and backpressure:
  - Pulse `host_out_valid` while in IDLE and twice while in RESP, with `rsp_ready` held 0 for 10 cycles.
  - Expected: `stray_count`=3, `rsp_data` stable throughout, `rsp_valid` stays high until the handshake.
- Reset in WAIT with 2 requests queued. Expected: outputs at reset values next cycle and FIFO empty. A subsequent tile result increments `stray_count`, and no response is produced.
